simt_alu_issuer: RTL and testbench

SIMT_ALU_ISSUER -- requirements
Module: simt_alu_issuer

---
 rtl/simt_alu_issuer.sv | 140 ++++++++++++++
 tb/tb_simt_alu_issuer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/simt_alu_issuer.sv
`default_nettype none
// ============================================================================
// Module  : simt_alu_issuer
// Purpose : Two-state issuer driving an external combinational ALU; results
//           are queued with the caller tag in an RSP_DEPTH-entry response FIFO.
//           Optional SIMT_ALU_ISSUER_PERF_EN adds saturating accept/stall counters.
// Revision: 1.0 - initial release
// ============================================================================
module simt_alu_issuer #(
  parameter int RSP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_opcode,
  input  logic [3:0]  req_a,
  input  logic [3:0]  req_b,
  input  logic [1:0]  req_tag,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [3:0]  alu_opcode,
  input  logic [3:0]  alu_result,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [3:0]  rsp_result,
  output logic        rsp_zero,
  output logic [1:0]  rsp_tag
`ifdef SIMT_ALU_ISSUER_PERF_EN
  ,
  output logic [15:0] perf_issued,
  output logic [15:0] perf_stall
`endif
);

  localparam int c_PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(RSP_DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  state_t               r_state;
  logic [3:0]           r_alu_a;
  logic [3:0]           r_alu_b;
  logic [3:0]           r_alu_op;
  logic [1:0]           r_tag;
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic [6:0]           r_mem [RSP_DEPTH];

  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic [6:0]           w_head;

  // Ready is forced low while reset is held so no accept can be seen then.
  assign req_ready = rst_n && (r_state == S_IDLE) && (r_count < c_DEPTH);
  assign w_accept  = req_valid && req_ready;
  assign w_push    = (r_state == S_EXEC);
  assign rsp_valid = (r_count != '0);
  assign w_pop     = rsp_valid && rsp_ready;
  assign w_head    = r_mem[r_rd_ptr];

  assign rsp_result = rsp_valid ? w_head[6:3] : 4'h0;
  assign rsp_zero   = rsp_valid ? w_head[2]   : 1'b0;
  assign rsp_tag    = rsp_valid ? w_head[1:0] : 2'h0;

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_opcode = r_alu_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_alu_a  <= 4'h0;
      r_alu_b  <= 4'h0;
      r_alu_op <= 4'h0;
      r_tag    <= 2'h0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_alu_a  <= req_a;
            r_alu_b  <= req_b;
            r_alu_op <= req_opcode;
            r_tag    <= req_tag;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // The full check at accept means a push never lands on a full FIFO.
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {alu_result, alu_zero, r_tag};
  end

`ifdef SIMT_ALU_ISSUER_PERF_EN
  logic [15:0] r_perf_issued;
  logic [15:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_issued <= 16'h0;
      r_perf_stall  <= 16'h0;
    end else begin
      if (w_accept && (r_perf_issued != 16'hFFFF))
        r_perf_issued <= r_perf_issued + 16'd1;
      if (req_valid && !req_ready && (r_perf_stall != 16'hFFFF))
        r_perf_stall <= r_perf_stall + 16'd1;
    end
  end

  assign perf_issued = r_perf_issued;
  assign perf_stall  = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_simt_alu_issuer.sv
`default_nettype none
// ============================================================================
// Module  : tb_simt_alu_issuer
// Purpose : Self-checking bench for simt_alu_issuer with a behavioural ALU and
//           a response scoreboard. Perf checks follow SIMT_ALU_ISSUER_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_simt_alu_issuer;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_opcode;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic [1:0] req_tag;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_opcode;
  logic [3:0] alu_result;
  logic       alu_zero;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_zero;
  logic [1:0] rsp_tag;
`ifdef SIMT_ALU_ISSUER_PERF_EN
  logic [15:0] perf_issued;
  logic [15:0] perf_stall;
`endif

  simt_alu_issuer #(.RSP_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_tag    (rsp_tag)
`ifdef SIMT_ALU_ISSUER_PERF_EN
    ,
    .perf_issued(perf_issued),
    .perf_stall (perf_stall)
`endif
  );

  // Behavioural ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, others pass A.
  always_comb begin
    case (alu_opcode)
      4'h0:    alu_result = alu_a + alu_b;
      4'h1:    alu_result = alu_a - alu_b;
      4'h2:    alu_result = alu_a & alu_b;
      4'h3:    alu_result = alu_a | alu_b;
      4'h4:    alu_result = alu_a ^ alu_b;
      default: alu_result = alu_a;
    endcase
    alu_zero = (alu_result == 4'h0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] tag;
    logic [3:0] res;
    logic       z;
  } vec_t;

  vec_t       vecs [8];
  logic [6:0] exp_q [$];
  logic [6:0] e;
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every pop is compared against the oldest accepted request.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got result %0h tag %0h, want none", rsp_result, rsp_tag);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_result", rsp_result, e[6:3]);
        chk("rsp_zero",   rsp_zero,   e[2]);
        chk("rsp_tag",    rsp_tag,    e[1:0]);
      end
    end
  end

  task automatic present(input vec_t v);
    req_valid  = 1'b1;
    req_opcode = v.op;
    req_a      = v.a;
    req_b      = v.b;
    req_tag    = v.tag;
  endtask

  // Returns #1 after the EXEC edge (N+1); the FSM is back in IDLE then.
  task automatic issue(input vec_t v);
    int n;
    n = 0;
    present(v);
    @(negedge clk);
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back({v.res, v.z, v.tag});
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("alu_a", alu_a, v.a);
    chk("alu_b", alu_b, v.b);
    chk("alu_opcode", alu_opcode, v.op);
    chk("exec_ready", req_ready, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready",  req_ready,  0);
    chk("rst_rsp_valid",  rsp_valid,  0);
    chk("rst_alu_a",      alu_a,      0);
    chk("rst_alu_b",      alu_b,      0);
    chk("rst_alu_opcode", alu_opcode, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_zero",   rsp_zero,   0);
    chk("rst_rsp_tag",    rsp_tag,    0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs[0] = '{4'h0, 4'h7, 4'h9, 2'd1, 4'h0, 1'b1};
    vecs[1] = '{4'h1, 4'h3, 4'h5, 2'd2, 4'hE, 1'b0};
    vecs[2] = '{4'h2, 4'hC, 4'hA, 2'd3, 4'h8, 1'b0};
    vecs[3] = '{4'h3, 4'h5, 4'h2, 2'd0, 4'h7, 1'b0};
    vecs[4] = '{4'h4, 4'hF, 4'hF, 2'd1, 4'h0, 1'b1};
    vecs[5] = '{4'h0, 4'h8, 4'h8, 2'd2, 4'h0, 1'b1};
    vecs[6] = '{4'h1, 4'h0, 4'h1, 2'd3, 4'hF, 1'b0};
    vecs[7] = '{4'h9, 4'hB, 4'h4, 2'd0, 4'hB, 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_opcode = 4'h0; req_a = 4'h0; req_b = 4'h0; req_tag = 2'h0;
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs();
    rst_n = 1'b1;
    #1 chk("post_rst_ready", req_ready, 1);

    // Fill the FIFO with the consumer stalled, then a fifth request waits.
    issue('{4'h0, 4'h1, 4'h1, 2'd1, 4'h2, 1'b0});
    chk("first_latency", rsp_valid, 1);
    issue('{4'h0, 4'h2, 4'h3, 2'd1, 4'h5, 1'b0});
    issue('{4'h1, 4'h4, 4'h4, 2'd2, 4'h0, 1'b1});
    issue('{4'h2, 4'h6, 4'h3, 2'd3, 4'h2, 1'b0});
    v = '{4'h3, 4'h0, 4'h0, 2'd0, 4'h0, 1'b1};
    present(v);
    repeat (3) begin
      @(negedge clk);
      chk("full_ready", req_ready, 0);
      chk("stable_head_result", rsp_result, 4'h2);
      chk("stable_head_tag", rsp_tag, 2'd1);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    issue(v);
    drain();
`ifdef SIMT_ALU_ISSUER_PERF_EN
    chk("perf_issued", perf_issued, 5);
    chk("perf_stall",  perf_stall,  4);
`endif

    // Table vectors, consumer always ready.
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i]);
      chk("rsp_latency", rsp_valid, 1);
    end
    drain();

    // Push and pop on the same edge with three entries queued.
    rsp_ready = 1'b0;
    issue('{4'h2, 4'hF, 4'h3, 2'd0, 4'h3, 1'b0});
    issue('{4'h3, 4'h8, 4'h1, 2'd1, 4'h9, 1'b0});
    issue('{4'h4, 4'h5, 4'h5, 2'd2, 4'h0, 1'b1});
    v = '{4'h0, 4'h2, 4'h2, 2'd3, 4'h4, 1'b0};
    present(v);
    @(negedge clk);
    chk("cnt3_ready", req_ready, 1);
    exp_q.push_back({v.res, v.z, v.tag});
    @(posedge clk);
    #1 req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 chk("cnt3_after_pushpop_ready", req_ready, 1);
    issue('{4'h1, 4'h9, 4'h1, 2'd0, 4'h8, 1'b0});
    issue('{4'h9, 4'h0, 4'h7, 2'd1, 4'h0, 1'b1});
    drain();

    // Reset while an operation is in EXEC discards it.
    present('{4'h0, 4'h3, 4'h4, 2'd2, 4'h7, 1'b0});
    @(negedge clk);
    chk("pre_rst_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst_n = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_ready", req_ready, 1);
    repeat (4) begin
      @(negedge clk);
      chk("no_stale_rsp", rsp_valid, 0);
    end
    @(posedge clk);
    #1 issue('{4'h1, 4'h6, 4'h2, 2'd3, 4'h4, 1'b0});
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
